fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller that sequences the 32-word instruction memory. It owns the program counter, drives the memory read address, and registers each returned word into an output slot with a valid/ready handshake toward decode. It handles branch redirects, halt-word detection and out-of-range address faults. It sits between the core's control path and the instruction memory.

## Interface
- DEPTH, 32, number of instruction words; valid addresses are 0..DEPTH-1 (word-indexed)
- RESET_PC, 32'd0, first fetch address after start/restart
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetching
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  begin fetching from RESET_PC (honoured only in IDLE or HALT)
- readAddress  output  32  word address to instruction memory (registered PC)
- Instruccion  input  32  combinational memory read data for readAddress
- instr_o  output  32  fetched instruction
- pc_o  output  32  address instr_o was fetched from
- instr_valid  output  1  instr_o/pc_o hold a valid instruction
- instr_ready  input  1  decode accepts instr_o this cycle
- branch_valid  input  1  redirect request
- branch_target  input  32  redirect word address
- halted  output  1  FSM in HALT
- fault  output  1  sticky: fetch attempted at address >= DEPTH

## Operation
- FSM states: IDLE, RUN, HALT. Reset -> IDLE.
- IDLE: no fetch. start -> RUN, PC <= RESET_PC.
- RUN, priority order per cycle:
  1. branch_valid=1: PC <= branch_target; instr_valid <= 0 (slot flushed, even if instr_ready=1); no capture.
  2. Slot free (instr_valid=0 or instr_ready=1) and PC >= DEPTH: no capture, instr_valid <= 0, fault <= 1, -> HALT.
  3. Slot free and PC < DEPTH: instr_o <= Instruccion, pc_o <= PC, instr_valid <= 1. If Instruccion == HALT_WORD -> HALT with PC unchanged; else PC <= PC+1 (32-bit wrap, irrelevant since >= DEPTH faults first).
  4. Slot full and instr_ready=0: hold everything.
- HALT: no capture. A pending instr_valid (including the HALT_WORD itself) stays until accepted, then drops. branch_valid ignored. start -> RUN, PC <= RESET_PC, fault <= 0, instr_valid <= 0.
- start in RUN ignored.
- Outputs in reset: readAddress=RESET_PC, instr_o=0, pc_o=0, instr_valid=0, halted=0, fault=0.

## Timing
- readAddress is registered PC; memory read is combinational; capture on the same edge → one-cycle fetch latency.
- start sampled at edge n: RUN and readAddress=RESET_PC after n; first instr_valid after n+1.
- Steady state with instr_ready=1: one instruction per cycle, sequential pc_o.
- Handshake: transfer when instr_valid & instr_ready; instr_o/pc_o stable while instr_valid & !instr_ready.
- Branch at edge n: instr_valid=0 after n; target instruction valid after n+1 (one bubble).
- halted asserts the cycle after the HALT transition; fault asserts on the same edge.
- reset asserted mid-operation clears immediately (async), regardless of handshake state.

## Configuration
- FETCH_PERF_EN: when defined, adds output fetch_count (32-bit) counting accepted transfers (instr_valid & instr_ready), and stall_count (32-bit) counting cycles with instr_valid & !instr_ready. Both clear on reset and on start, and saturate at all-ones. When undefined, neither port nor logic exists.

## Test plan
- Memory words 0..3 = 1,2,3,HALT_WORD, instr_ready=1, pulse start → instr_o 1,2,3,FFFF_FFFF with pc_o 0..3 on consecutive cycles, then halted=1, fault=0.
- Hold instr_ready=0 for 3 cycles while word 1 is valid → instr_o/pc_o frozen, readAddress frozen at 2; release → resumes with no loss or duplicate.
- branch_valid with target 10 while word 2 is valid and instr_ready=1 → instr_valid=0 next cycle, then pc_o=10 with its word.
- Branch to 30 with no halt words → pc_o 30, 31, then fault=1, halted=1, no instruction from address 32.
- Assert reset mid-RUN with instr_valid=1 → all outputs at reset values immediately; start → fetch resumes at RESET_PC with fault=0.
- FETCH_PERF_EN: 4 accepted transfers and 3 stall cycles → fetch_count=4, stall_count=3; after start both are 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller for a word-indexed instruction memory
//   clk/reset     : clock, asynchronous active-high reset
//   start         : begin fetching at RESET_PC (IDLE or HALT only)
//   readAddress   : registered PC driven to memory; Instruccion is its combinational read data
//   instr_o/pc_o  : captured instruction and its address, qualified by instr_valid/instr_ready
//   branch_valid/branch_target : redirect request
//   halted/fault  : FSM in HALT / sticky out-of-range fetch
//   FETCH_PERF_EN : adds saturating fetch_count and stall_count outputs
module fetch_sequencer #(
  parameter int          DEPTH     = 32,
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [31:0] readAddress,
  input  logic [31:0] Instruccion,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch_valid,
  input  logic [31:0] branch_target,
  output logic        halted,
  output logic        fault
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d, pco_q, pco_d;
  logic        valid_q, valid_d, fault_q, fault_d;
  logic        restart, slot_free;
  assign restart   = start && state_q != RUN;
  assign slot_free = !valid_q || instr_ready;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pco_d   = pco_q;
    valid_d = valid_q;
    fault_d = fault_q;
    if (restart) begin
      state_d = RUN;
      pc_d    = RESET_PC;
      valid_d = 1'b0;
      fault_d = 1'b0;
    end else if (state_q == RUN) begin
      if (branch_valid) begin
        pc_d    = branch_target;
        valid_d = 1'b0;
      end else if (slot_free && pc_q >= 32'(DEPTH)) begin
        valid_d = 1'b0;
        fault_d = 1'b1;
        state_d = HALT;
      end else if (slot_free) begin
        instr_d = Instruccion;
        pco_d   = pc_q;
        valid_d = 1'b1;
        state_d = Instruccion == HALT_WORD ? HALT : RUN;
        pc_d    = Instruccion == HALT_WORD ? pc_q : pc_q + 32'd1;
      end
    end else if (state_q == HALT && valid_q && instr_ready) begin
      valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      pco_q   <= '0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pco_q   <= pco_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
    end
  end
  assign readAddress = pc_q;
  assign instr_o     = instr_q;
  assign pc_o        = pco_q;
  assign instr_valid = valid_q;
  assign halted      = state_q == HALT;
  assign fault       = fault_q;
`ifdef FETCH_PERF_EN
  logic [31:0] fcnt_q, fcnt_d, scnt_q, scnt_d;
  always_comb begin
    fcnt_d = restart ? '0 : (valid_q && instr_ready && fcnt_q != '1) ? fcnt_q + 32'd1 : fcnt_q;
    scnt_d = restart ? '0 : (valid_q && !instr_ready && scnt_q != '1) ? scnt_q + 32'd1 : scnt_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fcnt_q <= '0;
      scnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_d;
      scnt_q <= scnt_d;
    end
  end
  assign fetch_count = fcnt_q;
  assign stall_count = scnt_q;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed self-checking bench for fetch_sequencer
module tb_fetch_sequencer;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, instr_ready = 1'b1, branch_valid = 1'b0;
  logic [31:0] branch_target = '0, readAddress, Instruccion, instr_o, pc_o;
  logic        instr_valid, halted, fault;
  logic [31:0] mem [0:63];
  int          evals = 0, fails = 0;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count, stall_count;
`endif
  fetch_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .readAddress(readAddress),
    .Instruccion(Instruccion), .instr_o(instr_o), .pc_o(pc_o),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .branch_valid(branch_valid), .branch_target(branch_target),
    .halted(halted), .fault(fault)
`ifdef FETCH_PERF_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );
  always #5 clk = ~clk;
  assign Instruccion = readAddress < 32'd64 ? mem[readAddress[5:0]] : 32'hDEAD_BEEF;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    evals++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic slot(input string tag, input logic v, input logic [31:0] ins, input logic [31:0] pc);
    chk({tag, "_valid"}, {31'd0, instr_valid}, {31'd0, v});
    if (v) begin
      chk({tag, "_instr"}, instr_o, ins);
      chk({tag, "_pc"}, pc_o, pc);
    end
  endtask
  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h100 + i;
    mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3; mem[3] = 32'hFFFF_FFFF;
    #2;
    chk("rst_ra", readAddress, 0); chk("rst_instr", instr_o, 0); chk("rst_pc", pc_o, 0);
    chk("rst_valid", {31'd0, instr_valid}, 0); chk("rst_halted", {31'd0, halted}, 0);
    chk("rst_fault", {31'd0, fault}, 0);
    @(negedge clk); reset = 1'b0;
    step(); chk("idle_ra", readAddress, 0); slot("idle", 0, 0, 0);
    start = 1'b1; step(); start = 1'b0;
    chk("start_ra", readAddress, 0); slot("start", 0, 0, 0);
    step(); slot("f0", 1, 1, 0); chk("f0_ra", readAddress, 1); chk("f0_halted", {31'd0, halted}, 0);
    step(); slot("f1", 1, 2, 1);
    step(); slot("f2", 1, 3, 2);
    step(); slot("f3", 1, 32'hFFFF_FFFF, 3); chk("f3_halted", {31'd0, halted}, 1);
    chk("f3_ra", readAddress, 3); chk("f3_fault", {31'd0, fault}, 0);
    step(); slot("hdrop", 0, 0, 0); chk("hdrop_halted", {31'd0, halted}, 1);
    start = 1'b1; step(); start = 1'b0;
    chk("rs_halted", {31'd0, halted}, 0); slot("rs", 0, 0, 0);
    step(); slot("s0", 1, 1, 0);
    step(); slot("s1", 1, 2, 1);
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); slot("stall", 1, 2, 1); chk("stall_ra", readAddress, 2);
    end
    instr_ready = 1'b1;
    step(); slot("s2", 1, 3, 2); chk("s2_ra", readAddress, 3);
    step(); slot("s3", 1, 32'hFFFF_FFFF, 3);
    start = 1'b1; step(); start = 1'b0;
    step(); slot("b0", 1, 1, 0);
    step(); slot("b1", 1, 2, 1);
    step(); slot("b2", 1, 3, 2);
    branch_valid = 1'b1; branch_target = 32'd10; step(); branch_valid = 1'b0;
    slot("bflush", 0, 0, 0); chk("bflush_ra", readAddress, 10);
    step(); slot("b10", 1, 32'h10A, 10); chk("b10_ra", readAddress, 11);
    branch_valid = 1'b1; branch_target = 32'd30; step(); branch_valid = 1'b0;
    slot("b30flush", 0, 0, 0);
    step(); slot("b30", 1, 32'h11E, 30);
    step(); slot("b31", 1, 32'h11F, 31); chk("b31_fault", {31'd0, fault}, 0);
    step(); slot("oor", 0, 0, 0); chk("oor_fault", {31'd0, fault}, 1);
    chk("oor_halted", {31'd0, halted}, 1); chk("oor_pc", pc_o, 31);
    step(); slot("oor2", 0, 0, 0); chk("oor2_fault", {31'd0, fault}, 1);
    start = 1'b1; step(); start = 1'b0;
    chk("clr_fault", {31'd0, fault}, 0); chk("clr_ra", readAddress, 0);
    step(); slot("r0", 1, 1, 0);
    reset = 1'b1; #1;
    chk("arst_ra", readAddress, 0); chk("arst_instr", instr_o, 0); chk("arst_pc", pc_o, 0);
    chk("arst_valid", {31'd0, instr_valid}, 0); chk("arst_halted", {31'd0, halted}, 0);
    chk("arst_fault", {31'd0, fault}, 0);
    @(negedge clk); reset = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    chk("rr_ra", readAddress, 0);
    step(); slot("rr0", 1, 1, 0); chk("rr0_fault", {31'd0, fault}, 0);
`ifdef FETCH_PERF_EN
    chk("perf_f0", fetch_count, 0); chk("perf_s0", stall_count, 0);
    instr_ready = 1'b0;
    step(); step(); step();
    instr_ready = 1'b1;
    step(); step(); step(); step();
    chk("perf_fetch", fetch_count, 4); chk("perf_stall", stall_count, 3);
    start = 1'b1; step(); start = 1'b0;
    chk("perf_fclr", fetch_count, 0); chk("perf_sclr", stall_count, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
    $finish;
  end
endmodule
